// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
// Write-side pointer and flag controller for the UART async FIFOs. Everything
// here runs in the write clock domain. The binary write pointer feeds the
// write-to-read Gray synchronizer. It never steps by more than +1 per clock, so
// each Gray transfer changes a single bit. The read pointer arrives already
// synchronized, as a binary value.
//
// Optional feature macro: FIFO_WR_OVERFLOW_DET_EN
//   When this macro is defined, a sticky overflow_err flag and its overflow_clr
//   input are added.
//
// Ports:
//   clk          write-domain clock
//   rst          synchronous reset, active-high; it overrides wr_en
//   wr_en        write request from the producer
//   rd_ptr_sync  binary read pointer, synchronized into clk (ADDR_WIDTH+1 bits)
//   wr_ptr       registered binary write pointer (ADDR_WIDTH+1 bits)
//   wr_addr      RAM write address, the low ADDR_WIDTH bits of wr_ptr
//   wr_accept    combinational RAM write enable: wr_en && !full
//   full         registered full flag
//   almost_full  registered flag: level >= AFULL_THRESH
//   level        registered fill level, 0..DEPTH
//   overflow_err (macro only) sticky flag, set one cycle after wr_en && full
//   overflow_clr (macro only) clears overflow_err; a new set wins over a clear
// -----------------------------------------------------------------------------
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = (2 ** ADDR_WIDTH) - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rd_ptr_sync,
    output logic [ADDR_WIDTH:0]   wr_ptr,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_accept,
    output logic                  full,
    output logic                  almost_full,
`ifdef FIFO_WR_OVERFLOW_DET_EN
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow_err,
    input  logic                  overflow_clr
`else
    output logic [ADDR_WIDTH:0]   level
`endif
);

    localparam int              DEPTH   = 2 ** ADDR_WIDTH;
    localparam int              PW      = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]   DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0]   AFULL_P = PW'(AFULL_THRESH);

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] level_r;
    logic          full_r;
    logic          almost_full_r;

    logic          wr_accept_s;
    logic [PW-1:0] wr_ptr_next_s;
    logic [PW-1:0] diff_s;
    logic [PW-1:0] level_next_s;
    logic          full_next_s;
    logic          almost_full_next_s;

    // Next-state logic. The flag "state machine" (empty/partial/afull/full) is
    // fully implied by the level, so there is no separate state register.
    always_comb begin
        wr_accept_s        = 1'b0;
        wr_ptr_next_s      = wr_ptr_r;
        diff_s             = {PW{1'b0}};
        level_next_s       = {PW{1'b0}};
        full_next_s        = 1'b0;
        almost_full_next_s = 1'b0;

        wr_accept_s   = wr_en && !full_r;
        // Modulo-2**PW arithmetic wraps the pointer with no special case.
        wr_ptr_next_s = wr_ptr_r + {{ADDR_WIDTH{1'b0}}, wr_accept_s};
        diff_s        = wr_ptr_next_s - rd_ptr_sync;

        // A diff above DEPTH can only come from a corrupt or unsynced read
        // pointer. It is treated as full, and the level saturates to DEPTH.
        if (diff_s >= DEPTH_P) begin
            full_next_s  = 1'b1;
            level_next_s = DEPTH_P;
        end else begin
            full_next_s  = 1'b0;
            level_next_s = diff_s;
        end

        if (level_next_s >= AFULL_P) begin
            almost_full_next_s = 1'b1;
        end else begin
            almost_full_next_s = 1'b0;
        end
    end

    // Pointer, level and flag registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r      <= {PW{1'b0}};
            level_r       <= {PW{1'b0}};
            full_r        <= 1'b0;
            almost_full_r <= 1'b0;
        end else begin
            wr_ptr_r      <= wr_ptr_next_s;
            level_r       <= level_next_s;
            full_r        <= full_next_s;
            almost_full_r <= almost_full_next_s;
        end
    end

`ifdef FIFO_WR_OVERFLOW_DET_EN
    logic overflow_err_r;

    // Sticky overflow flag. A write attempted while full sets it, and the set
    // takes priority over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_err_r <= 1'b0;
        end else if (wr_en && full_r) begin
            overflow_err_r <= 1'b1;
        end else if (overflow_clr) begin
            overflow_err_r <= 1'b0;
        end else begin
            overflow_err_r <= overflow_err_r;
        end
    end

    assign overflow_err = overflow_err_r;
`endif

    assign wr_ptr      = wr_ptr_r;
    assign wr_addr     = wr_ptr_r[ADDR_WIDTH-1:0];
    assign wr_accept   = wr_accept_s;
    assign full        = full_r;
    assign almost_full = almost_full_r;
    assign level       = level_r;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_ctrl
// Scoreboard bench for fifo_wr_ctrl. A driver applies directed and randomized
// stimulus on the falling edge. For each cycle it pushes the expected
// wr_accept and the expected post-edge register values onto a queue. It derives
// these from an integer model of the FIFO: a count of accepted writes and an
// occupancy computed modulo the pointer range. A separate monitor pops each
// entry. It checks wr_accept while the inputs are stable, and it checks the
// registered outputs just after the next rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_wr_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 2 ** AW;
    localparam int PW    = AW + 1;
    localparam int NPTR  = 2 ** PW;
    localparam int AFULL = DEPTH - 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b1;
    logic [PW-1:0] rd_ptr_sync = '0;
    logic [PW-1:0] wr_ptr;
    logic [AW-1:0] wr_addr;
    logic          wr_accept;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] level;
    logic          overflow_clr = 1'b0;
`ifdef FIFO_WR_OVERFLOW_DET_EN
    logic          overflow_err;
`endif

    fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(AFULL)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_ptr_sync (rd_ptr_sync),
        .wr_ptr      (wr_ptr),
        .wr_addr     (wr_addr),
        .wr_accept   (wr_accept),
        .full        (full),
        .almost_full (almost_full),
`ifdef FIFO_WR_OVERFLOW_DET_EN
        .level       (level),
        .overflow_err(overflow_err),
        .overflow_clr(overflow_clr)
`else
        .level       (level)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit chk_acc;
        bit acc;
        bit is_rst;
        int wp;
        int lvl;
        bit full;
        bit af;
        bit ovf;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    bit   mon_busy = 1'b0;

    // Reference model state
    int m_wp    = 0;
    bit m_full  = 1'b0;
    bit m_ovf   = 1'b0;
    bit m_known = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // One clock of stimulus. The expected results are computed from the
    // occupancy rules and pushed onto the queue.
    task automatic cycle(input bit r, input bit w, input int rd, input bit clr);
        exp_t e;
        int   diff;
        @(negedge clk);
        rst          = r;
        wr_en        = w;
        rd_ptr_sync  = rd[PW-1:0];
        overflow_clr = clr;
        e.chk_acc = m_known;
        e.acc     = w && !m_full;
        e.is_rst  = r;
        if (r) begin
            m_wp   = 0;
            m_full = 1'b0;
            m_ovf  = 1'b0;
            e.lvl  = 0;
            e.af   = 1'b0;
        end else begin
            if (w && m_full) m_ovf = 1'b1;
            else if (clr)    m_ovf = 1'b0;
            m_wp   = (m_wp + (e.acc ? 1 : 0)) % NPTR;
            diff   = (((m_wp - rd) % NPTR) + NPTR) % NPTR;
            m_full = (diff >= DEPTH);
            e.lvl  = (diff > DEPTH) ? DEPTH : diff;
            e.af   = (e.lvl >= AFULL);
        end
        e.wp    = m_wp;
        e.full  = m_full;
        e.ovf   = m_ovf;
        m_known = 1'b1;
        q.push_back(e);
    endtask

    // Monitor: it compares the DUT against each queued expectation.
    initial begin : monitor
        exp_t e;
        logic [PW-1:0] prev_ptr;
        bit prev_ok;
        prev_ok = 1'b0;
        prev_ptr = '0;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                mon_busy = 1'b1;
                if (e.chk_acc) chk("wr_accept", {31'd0, wr_accept}, {31'd0, e.acc});
                @(posedge clk);
                #1;
                chk("wr_ptr", {27'd0, wr_ptr}, e.wp);
                chk("wr_addr", {28'd0, wr_addr}, e.wp % DEPTH);
                chk("level", {27'd0, level}, e.lvl);
                chk("full", {31'd0, full}, {31'd0, e.full});
                chk("almost_full", {31'd0, almost_full}, {31'd0, e.af});
`ifdef FIFO_WR_OVERFLOW_DET_EN
                chk("overflow_err", {31'd0, overflow_err}, {31'd0, e.ovf});
`endif
                if (prev_ok && !e.is_rst)
                    chk("gray_step", $countones(bin2gray(prev_ptr) ^ bin2gray(wr_ptr)) <= 1 ? 32'd1 : 32'd0, 32'd1);
                prev_ptr = wr_ptr;
                prev_ok  = 1'b1;
                mon_busy = 1'b0;
            end
        end
    end

    // Driver: it applies the directed scenarios and then random traffic.
    initial begin : driver
        int guard;
        int rd;
        // Reset held for 3 clocks with wr_en high
        repeat (3) cycle(1'b1, 1'b1, 0, 1'b0);
        // Fill from empty, then one extra write while full
        repeat (17) cycle(1'b0, 1'b1, 0, 1'b0);
        // Drain release: read pointer steps 0 -> 1
        cycle(1'b0, 1'b0, 1, 1'b0);
        cycle(1'b0, 1'b0, 1, 1'b0);
        // Preload to wr_ptr == rd_ptr_sync == 30 with matched reads
        guard = 0;
        while (m_wp != 30 && guard < 64) begin
            cycle(1'b0, 1'b1, (m_wp + 1) % NPTR, 1'b0);
            guard++;
        end
        // Wrap: 31, 0, 1, 2 at constant level
        repeat (4) cycle(1'b0, 1'b1, (m_wp + 1) % NPTR, 1'b0);
        // Corrupt read pointer giving diff 24, then a write attempt, then recovery
        cycle(1'b0, 1'b0, (m_wp - 24 + NPTR) % NPTR, 1'b0);
        cycle(1'b0, 1'b1, (m_wp - 24 + NPTR) % NPTR, 1'b0);
        cycle(1'b0, 1'b0, m_wp, 1'b0);
        // Refill for the overflow flag: set, hold, clear, then clear coincident with a set
        rd = m_wp;
        repeat (DEPTH) cycle(1'b0, 1'b1, rd, 1'b0);
        cycle(1'b0, 1'b1, rd, 1'b0);
        cycle(1'b0, 1'b0, rd, 1'b0);
        cycle(1'b0, 1'b0, rd, 1'b1);
        cycle(1'b0, 1'b0, rd, 1'b0);
        cycle(1'b0, 1'b1, rd, 1'b1);
        cycle(1'b0, 1'b0, rd, 1'b0);
        // Randomized traffic: a read pointer within the legal window, with the
        // occasional corrupt value or reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0)
                rd = $urandom_range(0, NPTR - 1);
            else
                rd = (m_wp - int'($urandom_range(0, DEPTH)) + NPTR) % NPTR;
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), rd,
                  ($urandom_range(0, 7) == 0));
        end
        // Let the monitor drain, with a bounded wait
        guard = 0;
        while ((q.size() > 0 || mon_busy) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        #3;
        if (q.size() > 0 || mon_busy) begin
            n_chk++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
